// File: rtl/note_sequencer.sv
// Multi-channel note recorder/player: per-channel {octave,note} buffers stepped at a fixed tempo.
// Define NOTE_SEQ_LOOP_EN to loop the sequence instead of returning to IDLE at its end.
module note_sequencer #(
  parameter int CHANNELS       = 2,
  parameter int DEPTH          = 16,
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter int FREQ_W         = 32,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int NW            = AW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rec_valid,
  input  logic [CW-1:0]              rec_channel,
  input  logic [3:0]                 rec_note,
  input  logic [1:0]                 rec_octave,
  input  logic                       play,
  input  logic                       stop,
  input  logic                       clear,
  output logic [CHANNELS*FREQ_W-1:0] freq_out,
  output logic                       playing,
  output logic [AW-1:0]              step_idx,
  output logic [CHANNELS*NW-1:0]     count,
  output logic                       overflow
);

  localparam int TW = $clog2(TICKS_PER_STEP);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              step_q, step_d;
  logic [TW-1:0]              tick_q, tick_d;
  logic [CHANNELS*FREQ_W-1:0] freq_q, freq_d, step_freq;
  logic [NW-1:0]              cnt_q [CHANNELS];
  logic [NW-1:0]              seq_len;
  logic [5:0]                 mem [CHANNELS][DEPTH];
  logic                       overflow_q;
  logic                       play_go, rec_ch_ok, rec_en, rec_full;

  function automatic logic [FREQ_W-1:0] note_hz(input logic [5:0] entry);
    logic [8:0]  base;
    logic [11:0] hz;
    case (entry[3:0])
      4'd1:    base = 9'd262;
      4'd2:    base = 9'd277;
      4'd3:    base = 9'd294;
      4'd4:    base = 9'd311;
      4'd5:    base = 9'd330;
      4'd6:    base = 9'd349;
      4'd7:    base = 9'd370;
      4'd8:    base = 9'd392;
      4'd9:    base = 9'd415;
      4'd10:   base = 9'd440;
      4'd11:   base = 9'd466;
      4'd12:   base = 9'd494;
      default: base = 9'd0;
    endcase
    hz = {3'b000, base} << entry[5:4];
    return FREQ_W'(hz);
  endfunction

  // Sequence length is the longest channel; shorter channels rest past their end.
  always_comb begin
    seq_len = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (cnt_q[c] > seq_len) seq_len = cnt_q[c];
  end

  always_comb begin
    step_freq = '0;
    for (int c = 0; c < CHANNELS; c++)
      if ({1'b0, step_q} < cnt_q[c])
        step_freq[c*FREQ_W +: FREQ_W] = note_hz(mem[c][step_q]);
  end

  // Priority: clear > stop > play > rec_valid.
  assign play_go   = play && (seq_len != '0) && !clear && !stop;
  assign rec_ch_ok = int'(rec_channel) < CHANNELS;
  assign rec_en    = rec_valid && rec_ch_ok && (state_q == IDLE) && !clear && !stop && !play_go;
  assign rec_full  = cnt_q[rec_channel] == NW'(DEPTH);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick_d  = tick_q;
    freq_d  = '0;
    if (clear || stop) begin
      state_d = IDLE;
      step_d  = '0;
      tick_d  = '0;
    end else if (play_go) begin
      state_d = PLAY;
      step_d  = '0;
      tick_d  = '0;
      if (state_q == PLAY) freq_d = step_freq;
    end else if (state_q == PLAY) begin
      freq_d = step_freq;
      if (tick_q == TW'(TICKS_PER_STEP - 1)) begin
        tick_d = '0;
        if ({1'b0, step_q} == seq_len - NW'(1)) begin
`ifdef NOTE_SEQ_LOOP_EN
          step_d = '0;
`else
          state_d = IDLE;
          step_d  = '0;
          freq_d  = '0;
`endif
        end else begin
          step_d = step_q + AW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      tick_q     <= '0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      freq_q  <= freq_d;
      if (clear) begin
        overflow_q <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      end else if (rec_en) begin
        if (rec_full) overflow_q <= 1'b1;
        else          cnt_q[rec_channel] <= cnt_q[rec_channel] + NW'(1);
      end
    end
  end

  // Buffer contents survive reset and clear; only the counts define what is valid.
  always_ff @(posedge clk) begin
    if (rec_en && !rec_full)
      mem[rec_channel][cnt_q[rec_channel][AW-1:0]] <= {rec_octave, rec_note};
  end

  always_comb begin
    count = '0;
    for (int c = 0; c < CHANNELS; c++) count[c*NW +: NW] = cnt_q[c];
  end

  assign freq_out = freq_q;
  assign playing  = (state_q == PLAY);
  assign step_idx = step_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a queue-based model predicts the per-cycle playback trace.
module tb_note_sequencer;
  localparam int CH  = 2;
  localparam int DP  = 4;
  localparam int TPS = 4;
  localparam int FW  = 32;
  localparam int CW  = 1;
  localparam int AW  = 2;
  localparam int NW  = 3;
  localparam int W   = 1 + AW + CH*FW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rec_valid = 1'b0;
  logic [CW-1:0]   rec_channel = '0;
  logic [3:0]      rec_note = '0;
  logic [1:0]      rec_octave = '0;
  logic            play = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [CH*FW-1:0] freq_out;
  logic            playing;
  logic [AW-1:0]   step_idx;
  logic [CH*NW-1:0] count;
  logic            overflow;

  note_sequencer #(.CHANNELS(CH), .DEPTH(DP), .TICKS_PER_STEP(TPS), .FREQ_W(FW)) dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_channel(rec_channel),
    .rec_note(rec_note), .rec_octave(rec_octave), .play(play), .stop(stop), .clear(clear),
    .freq_out(freq_out), .playing(playing), .step_idx(step_idx), .count(count),
    .overflow(overflow)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  int         base_tab [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};
  logic [5:0] mbuf [CH][$];
  bit         m_ovf = 1'b0;
  logic [W-1:0] exp_q [$];
  int n_pass = 0, n_total = 0;

  function automatic int note_hz(input logic [5:0] e);
    int n = int'(e[3:0]);
    if (n < 1 || n > 12) return 0;
    return base_tab[n-1] * (1 << int'(e[5:4]));
  endfunction

  function automatic int seq_len();
    int l = 0;
    for (int c = 0; c < CH; c++) if (mbuf[c].size() > l) l = mbuf[c].size();
    return l;
  endfunction

  // Expected {playing, step_idx, freq_out} j cycles after play was accepted (j<0: still idle).
  function automatic logic [W-1:0] exp_at(input int j);
    int l = seq_len();
    bit pl;
    int st, prev;
    logic [CH*FW-1:0] f = '0;
    if (j < 0 || l == 0) return '0;
    if (LOOP) begin
      pl = 1'b1;
      st = (j / TPS) % l;
      prev = ((j - 1) / TPS) % l;
    end else begin
      pl = (j / TPS) < l;
      st = pl ? j / TPS : 0;
      prev = (j - 1) / TPS;
    end
    if (pl && j >= 1)
      for (int c = 0; c < CH; c++)
        if (prev < mbuf[c].size()) f[c*FW +: FW] = FW'(note_hz(mbuf[c][prev]));
    return {pl, AW'(st), f};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("trace playing/step/freq", 128'({playing, step_idx, freq_out}), 128'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_counts();
    for (int c = 0; c < CH; c++)
      check($sformatf("count[%0d]", c), 128'(count[c*NW +: NW]), 128'(mbuf[c].size()));
    check("overflow", 128'(overflow), 128'(m_ovf));
  endtask

  task automatic rec(input int ch, input int note, input int oct);
    @(posedge clk); #1;
    rec_valid = 1'b1; rec_channel = CW'(ch); rec_note = 4'(note); rec_octave = 2'(oct);
    if (mbuf[ch].size() < DP) mbuf[ch].push_back({2'(oct), 4'(note)});
    else m_ovf = 1'b1;
    @(posedge clk); #1;
    rec_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int c = 0; c < CH; c++) mbuf[c].delete();
    m_ovf = 1'b0;
    check_counts();
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge clk); k++;
    end
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));
    #1;
  endtask

  // Play for n cycles, then stop (optionally together with play); optionally record mid-play.
  task automatic run_play(input int n, input bit both, input bit rec_mid);
    @(posedge clk); #1;
    play = 1'b1;
    for (int i = 0; i <= n; i++) exp_q.push_back(exp_at(i - 1));
    @(posedge clk); #1;
    play = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      rec_valid = rec_mid && (i == 1);
      rec_channel = CW'($urandom_range(0, CH - 1));
      rec_note = 4'($urandom_range(1, 12));
    end
    stop = 1'b1; play = both;
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    stop = 1'b0; play = 1'b0;
    wait_drain();
    check_counts();
  endtask

  function automatic int play_len();
    int l = seq_len();
    if (LOOP) return $urandom_range(4, 3 * l * TPS + 4);
    return l * TPS + $urandom_range(2, 5);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int c = 0; c < CH; c++) mbuf[c].delete();
    repeat (3) @(posedge clk);
    #1;
    check("reset freq_out", 128'(freq_out), 128'(0));
    check("reset playing", 128'(playing), 128'(0));
    check("reset step_idx", 128'(step_idx), 128'(0));
    check_counts();
    @(negedge clk); reset = 1'b0;

    // Directed: ch0 A0, C1; ch1 E2
    rec(0, 10, 0); rec(0, 1, 1); rec(1, 5, 2);
    check_counts();
    check("model A0/C1/E2", 128'({exp_at(1), exp_at(5)}),
          128'({1'b1, 2'd0, 32'd1320, 32'd440, 1'b1, 2'd1, 32'd0, 32'd524}));
    run_play(LOOP ? 20 : 12, 1'b0, 1'b1);
    run_play(6, 1'b1, 1'b0);

    // Overflow on ch1, then clear
    do_clear();
    for (int i = 0; i < DP + 1; i++) rec(1, $urandom_range(1, 12), $urandom_range(0, 3));
    check_counts();
    run_play(play_len(), 1'b0, 1'b0);
    do_clear();

    // Empty play, then rec+play together on empty buffers
    run_play(6, 1'b0, 1'b0);
    @(posedge clk); #1;
    rec_valid = 1'b1; play = 1'b1; rec_channel = '0; rec_note = 4'd3; rec_octave = 2'd0;
    repeat (3) exp_q.push_back('0);
    mbuf[0].push_back({2'd0, 4'd3});
    @(posedge clk); #1;
    rec_valid = 1'b0; play = 1'b0;
    wait_drain();
    check_counts();

    // Rest codes and the highest frequency
    do_clear();
    rec(0, 14, 2); rec(1, 12, 3); rec(0, 0, 1);
    run_play(play_len(), 1'b0, 1'b0);

    // Randomised rounds
    for (int r = 0; r < 8; r++) begin
      int nrec;
      do_clear();
      nrec = $urandom_range(1, 2 * DP + 2);
      for (int i = 0; i < nrec; i++)
        rec($urandom_range(0, CH - 1), $urandom_range(0, 15), $urandom_range(0, 3));
      check_counts();
      run_play(play_len(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Async reset mid-step with overflow set
    do_clear();
    for (int i = 0; i < DP + 1; i++) rec(0, $urandom_range(1, 12), $urandom_range(0, 3));
    rec(1, 7, 1);
    @(posedge clk); #1; play = 1'b1;
    @(posedge clk); #1; play = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < CH; c++) mbuf[c].delete();
    m_ovf = 1'b0;
    check("async reset freq_out", 128'(freq_out), 128'(0));
    check("async reset playing", 128'(playing), 128'(0));
    check("async reset step_idx", 128'(step_idx), 128'(0));
    check_counts();
    @(negedge clk); reset = 1'b0;
    rec(1, 9, 0);
    run_play(play_len(), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised multi-channel note recorder and player for the music device. It sits between keyboard decoding (`convert_keyboard_input`) and the audio generator. Per-channel {octave, note} steps are stored in on-chip buffers. On command it steps through them at a fixed tempo and drives one frequency word per channel. It generalises the single-channel record/playback `control`/`datapath` pair to N channels, configurable depth, tempo, stop/clear and overflow reporting.

## Interface
Parameters:
- `CHANNELS`, 2 — number of independent note channels (1–4).
- `DEPTH`, 16 — steps per channel buffer (power of two, 4–64).
- `TICKS_PER_STEP`, 12_500_000 — clk cycles per playback step (0.25 s at 50 MHz); minimum 2.
- `FREQ_W`, 32 — width of each frequency word.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1 — system clock (CLOCK_50).
- `reset` in 1 — async active-high reset.
- `rec_valid` in 1 — one-cycle strobe; append an entry to channel `rec_channel`.
- `rec_channel` in max(1,$clog2(CHANNELS)) — target channel.
- `rec_note` in 4 — 0 = rest; 1–12 = C..B; 13–15 = rest.
- `rec_octave` in 2 — octave offset 0–3.
- `play` in 1 — one-cycle strobe; start playback from step 0.
- `stop` in 1 — one-cycle strobe; abort playback.
- `clear` in 1 — one-cycle strobe; empty all buffers.
- `freq_out` out CHANNELS*FREQ_W — channel c occupies bits [c*FREQ_W +: FREQ_W]; Hz.
- `playing` out 1 — high in PLAY state.
- `step_idx` out $clog2(DEPTH) — current playback step.
- `count` out CHANNELS*($clog2(DEPTH)+1) — entries per channel.
- `overflow` out 1 — sticky; a record was dropped because its channel was full.

## Operation
- States: IDLE, PLAY. Reset → IDLE, all counts 0, `freq_out` 0, `playing` 0, `step_idx` 0, `overflow` 0. Buffer contents are not reset.
- Record (IDLE only): on `rec_valid`, write {octave,note} at index count[ch], then count[ch]++. If count[ch]==DEPTH, drop the write and set `overflow`. `rec_valid` in PLAY is ignored; it does not set overflow.
- `rec_channel` ≥ CHANNELS: write ignored.
- Sequence length L = max over channels of count[c].
- IDLE→PLAY on `play` when L>0; `play` with L==0 is ignored. `step_idx` is loaded with 0 and the tick counter with 0.
- In PLAY, channel c outputs the frequency of entry[step_idx] if step_idx < count[c], else 0 (rest).
- Frequency: base table for octave 0 is C 262, C# 277, D 294, D# 311, E 330, F 349, F# 370, G 392, G# 415, A 440, A# 466, B 494. Result = base << octave, zero-extended to FREQ_W. Notes 0 and 13–15 give 0.
- Step advance: the tick counter counts 0..TICKS_PER_STEP-1. On wrap, step_idx++. On wrap with step_idx==L-1, the end-of-sequence behaviour applies (see Configuration).
- PLAY→IDLE on `stop` or `clear`. All `freq_out` go to 0, `step_idx` goes to 0.
- `clear` (any state): all counts → 0 and `overflow` → 0.
- Priority within one cycle: clear > stop > play > rec_valid.
- `play` while in PLAY restarts at step 0 with the tick counter at 0.

## Timing
- All outputs are registered.
- `play` at edge k: `playing`=1 and `step_idx`=0 after edge k+1; `freq_out` shows step 0 after edge k+2 (one cycle of table lookup).
- Step change: `step_idx` updates on the edge that wraps the tick counter; `freq_out` follows one cycle later.
- `count` updates the cycle after `rec_valid`. `overflow` sets the cycle after the dropped write.
- `stop`/`clear` at edge k: `playing`=0 and `freq_out`=0 after edge k+1.
- Async reset asserts all outputs to their reset values immediately, including mid-playback. Release is synchronous to the next clk edge.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined: at end of sequence, step_idx wraps to 0 and playback continues until `stop`/`clear`.
- Not defined: at end of sequence, go to IDLE. The next cycle `playing`=0, `step_idx`=0, and `freq_out`=0.

## Test plan
- Reset, TICKS_PER_STEP=4. Record ch0: (A,oct0), (C,oct1); ch1: (E,oct2). Pulse `play`. Required:
  - ch0 `freq_out` = 440 then 524.
  - ch1 `freq_out` = 1320 then 0.
  - Each value held 4 cycles.
  - counts = 2/1.
- Same sequence, macro undefined: `playing` drops one cycle after step 1 ends and `freq_out`=0. With `NOTE_SEQ_LOOP_EN`, ch0 returns to 440 after 8 cycles.
- Write DEPTH+1 entries to ch1: count[1]=DEPTH, `overflow`=1, last entry not stored. Then `clear`: counts 0, `overflow` 0.
- `play` with all counts 0: `playing` stays 0. Then `rec_valid` and `play` in the same cycle with an empty buffer: the write is recorded and playback does not start.
- Mid-playback `stop` and `play` in the same cycle: stop wins, `playing`=0 next cycle. `rec_valid` during PLAY leaves `count` unchanged.
- Assert `reset` mid-step: `freq_out`, `playing`, `step_idx`, `count`, `overflow` all 0 with no clock edge. Note 14 recorded and played gives freq 0.
